// File: rtl/mem_arbiter.sv
// Shares one single-port program memory between CPU fetch and a debug/loader port; fixed CPU priority bounded by a starvation counter.
// Latency: grant is combinational, *Valid/data one cycle after accept. Backpressure: a loser simply sees ready low and holds its request.
// Optional feature: define MEM_ARB_DBG_WRITE_EN to let the debug port write memory; otherwise every debug access is a read.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuReq,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  output logic                  cpuReady,
  output logic [DATA_WIDTH-1:0] cpuData,
  output logic                  cpuValid,
  input  logic                  dbgReq,
  input  logic                  dbgWe,
  input  logic [ADDR_WIDTH-1:0] dbgAddr,
  input  logic [DATA_WIDTH-1:0] dbgWData,
  output logic                  dbgReady,
  output logic [DATA_WIDTH-1:0] dbgRData,
  output logic                  dbgValid,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memStrobe,
  output logic                  memWe,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memDataRead
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  owner_t     r_owner;
  owner_t     w_owner_nxt;
  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_cnt_nxt;
  logic       w_dbg_force;
  logic       w_dbg_we;

`ifdef MEM_ARB_DBG_WRITE_EN
  assign w_dbg_we = dbgWe;
`else
  logic w_unused_dbg;
  assign w_dbg_we     = 1'b0;
  assign w_unused_dbg = dbgWe ^ (^dbgWData);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= OWN_NONE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Grants are gated by reset so nothing reaches memory while the block is held.
  always_comb begin
    w_dbg_force    = dbgReq & (r_wait_cnt == LP_MAX_WAIT);
    dbgReady       = ~reset & dbgReq & (~cpuReq | w_dbg_force);
    cpuReady       = ~reset & cpuReq & ~w_dbg_force;

    memStrobe      = cpuReady | dbgReady;
    memWe          = dbgReady & w_dbg_we;
    memAddr        = '0;
    memWData       = '0;
    if (dbgReady) begin
      memAddr = dbgAddr;
    end else if (!reset) begin
      memAddr = cpuAddr;
    end
`ifdef MEM_ARB_DBG_WRITE_EN
    if (memWe) begin
      memWData = dbgWData;
    end
`endif

    w_owner_nxt = OWN_NONE;
    if (cpuReady) begin
      w_owner_nxt = OWN_CPU;
    end else if (dbgReady) begin
      w_owner_nxt = OWN_DBG;
    end

    // Count consecutive denied debug cycles; saturate so the force condition holds.
    w_wait_cnt_nxt = 4'd0;
    if (dbgReq && !dbgReady) begin
      w_wait_cnt_nxt = (r_wait_cnt == LP_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 4'd1;
    end

    cpuValid = ~reset & (r_owner == OWN_CPU);
    dbgValid = ~reset & (r_owner == OWN_DBG);
    cpuData  = memDataRead;
    dbgRData = memDataRead;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered memory model; expected values are hand-computed.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpuReq;
  logic [7:0] cpuAddr;
  logic       cpuReady;
  logic [7:0] cpuData;
  logic       cpuValid;
  logic       dbgReq;
  logic       dbgWe;
  logic [7:0] dbgAddr;
  logic [7:0] dbgWData;
  logic       dbgReady;
  logic [7:0] dbgRData;
  logic       dbgValid;
  logic [7:0] memAddr;
  logic       memStrobe;
  logic       memWe;
  logic [7:0] memWData;
  logic [7:0] memDataRead;

  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_dat;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuAddr(cpuAddr), .cpuReady(cpuReady), .cpuData(cpuData), .cpuValid(cpuValid),
    .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWData(dbgWData),
    .dbgReady(dbgReady), .dbgRData(dbgRData), .dbgValid(dbgValid),
    .memAddr(memAddr), .memStrobe(memStrobe), .memWe(memWe), .memWData(memWData),
    .memDataRead(memDataRead)
  );

  always #5 clk = ~clk;

  // Registered single-port memory; preload port used only while the arbiter is idle.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_dat;
    end else if (memStrobe) begin
      if (memWe) mem[memAddr] <= memWData;
      memDataRead <= mem[memAddr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after negedge; outputs are sampled 2ns later, mid-low-phase.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    next_cycle();
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    next_cycle();
    pre_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpuReq = 1'b0; cpuAddr = 8'h00;
    dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = 8'h00; dbgWData = 8'h00;
    pre_we = 1'b0; pre_addr = 8'h00; pre_dat = 8'h00; memDataRead = 8'h00;

    // Reset: requests present but nothing granted or issued.
    next_cycle();
    cpuReq = 1'b1; cpuAddr = 8'h44; dbgReq = 1'b1;
    settle();
    chk("rst_cpuReady", cpuReady, 0);
    chk("rst_dbgReady", dbgReady, 0);
    chk("rst_memStrobe", memStrobe, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_valids", {cpuValid, dbgValid}, 0);
    next_cycle();
    cpuReq = 1'b0; dbgReq = 1'b0; cpuAddr = 8'h00;
    preload(8'h10, 8'hA5);
    preload(8'h00, 8'h11);
    preload(8'h01, 8'h22);
    preload(8'h05, 8'h99);
    preload(8'h30, 8'h5A);
    reset = 1'b0;

    // CPU-only read.
    next_cycle();
    cpuReq = 1'b1; cpuAddr = 8'h10;
    settle();
    chk("cpu_rd_ready", cpuReady, 1);
    chk("cpu_rd_strobe", memStrobe, 1);
    chk("cpu_rd_addr", memAddr, 8'h10);
    next_cycle();
    cpuReq = 1'b0;
    settle();
    chk("cpu_rd_valid", cpuValid, 1);
    chk("cpu_rd_data", cpuData, 8'hA5);
    chk("cpu_rd_dbgValid", dbgValid, 0);
    next_cycle();
    settle();
    chk("cpu_rd_valid_once", cpuValid, 0);

    // Debug-only read wins with no CPU contention.
    next_cycle();
    dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 8'h30;
    settle();
    chk("dbg_rd_ready", dbgReady, 1);
    chk("dbg_rd_addr", memAddr, 8'h30);
    next_cycle();
    dbgReq = 1'b0;
    settle();
    chk("dbg_rd_valid", {cpuValid, dbgValid}, 2'b01);
    chk("dbg_rd_data", dbgRData, 8'h5A);

    // Starvation bound: debug granted at cycles 4 and 9 under continuous contention.
    next_cycle();
    cpuReq = 1'b1; cpuAddr = 8'h10; dbgReq = 1'b1; dbgAddr = 8'h30;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk($sformatf("starve_c%0d", c), {cpuReady, dbgReady},
          (c == 4 || c == 9) ? 2'b01 : 2'b10);
      if (c == 4) chk("starve_dbg_addr", memAddr, 8'h30);
      next_cycle();
    end
    cpuReq = 1'b0; dbgReq = 1'b0;
    settle();
    chk("starve_tail_dbgValid", dbgValid, 1);

    // Debug write then CPU read of the same address.
    next_cycle();
    dbgReq = 1'b1; dbgWe = 1'b1;
`ifdef MEM_ARB_DBG_WRITE_EN
    dbgAddr = 8'h20; dbgWData = 8'h3C;
    settle();
    chk("wr_dbgReady", dbgReady, 1);
    chk("wr_memWe", memWe, 1);
    chk("wr_memWData", memWData, 8'h3C);
    next_cycle();
    dbgReq = 1'b0; dbgWe = 1'b0; cpuReq = 1'b1; cpuAddr = 8'h20;
    settle();
    chk("wr_ack", dbgValid, 1);
    chk("wr_rd_cpuReady", cpuReady, 1);
    next_cycle();
    cpuReq = 1'b0;
    settle();
    chk("wr_rd_valid", cpuValid, 1);
    chk("wr_rd_data", cpuData, 8'h3C);
`else
    dbgAddr = 8'h05; dbgWData = 8'h77;
    settle();
    chk("nowr_dbgReady", dbgReady, 1);
    chk("nowr_memWe", memWe, 0);
    chk("nowr_memWData", memWData, 0);
    next_cycle();
    dbgReq = 1'b0; dbgWe = 1'b0; cpuReq = 1'b1; cpuAddr = 8'h05;
    settle();
    chk("nowr_ack", dbgValid, 1);
    chk("nowr_rdata", dbgRData, 8'h99);
    next_cycle();
    cpuReq = 1'b0;
    settle();
    chk("nowr_rd_valid", cpuValid, 1);
    chk("nowr_rd_data", cpuData, 8'h99);
`endif

    // Back-to-back CPU reads.
    next_cycle();
    cpuReq = 1'b1; cpuAddr = 8'h00;
    settle();
    chk("b2b_ready0", cpuReady, 1);
    next_cycle();
    cpuAddr = 8'h01;
    settle();
    chk("b2b_ready1", cpuReady, 1);
    chk("b2b_valid1", cpuValid, 1);
    chk("b2b_data1", cpuData, 8'h11);
    next_cycle();
    cpuReq = 1'b0;
    settle();
    chk("b2b_valid2", cpuValid, 1);
    chk("b2b_data2", cpuData, 8'h22);
    next_cycle();
    settle();
    chk("b2b_valid3", cpuValid, 0);

    // Request dropped before acceptance issues nothing.
    chk("idle_strobe", memStrobe, 0);

    // Reset mid-access with debug waiting (counter non-zero going into reset).
    next_cycle();
    cpuReq = 1'b1; cpuAddr = 8'h10; dbgReq = 1'b1; dbgAddr = 8'h30;
    settle();
    chk("rmid_accept", cpuReady, 1);
    next_cycle();
    cpuReq = 1'b0; cpuAddr = 8'h00; reset = 1'b1;
    settle();
    chk("rmid_cpuValid_c1", cpuValid, 0);
    chk("rmid_outs_c1", {cpuReady, dbgReady, memStrobe, memWe, dbgValid}, 0);
    next_cycle();
    reset = 1'b0; dbgReq = 1'b0;
    settle();
    chk("rmid_cpuValid_c2", cpuValid, 0);
    chk("rmid_outs_c2", {cpuReady, dbgReady, memStrobe, memWe, dbgValid, memAddr, memWData}, 0);
    chk("rmid_waitCnt", dut.r_wait_cnt, 0);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
